// File: rtl/aqed_fifo_fc_checker_pkg.sv
// Shared types for the A-QED FIFO functional-consistency checker.
//   aqed_state_t : monitor FSM states
//   CAP_W        : width of the captured-data field (DATA_W must not exceed it)
//   aqed_cap_t   : one captured pop result {data, seen}
//   sat_max()    : saturating maximum of a W-bit counter (W <= 32)
package aqed_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ORIG = 2'd1,
    DUP  = 2'd2,
    DONE = 2'd3
  } aqed_state_t;

  localparam int unsigned CAP_W = 64;

  typedef struct packed {
    logic [CAP_W-1:0] data;
    logic             seen;
  } aqed_cap_t;

  function automatic logic [31:0] sat_max(input int unsigned w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/aqed_fifo_fc_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force count to zero (wins over inc)
//   inc        : increment by one unless already at MAX
//   cnt        : current count
//   sat        : count equals MAX
module aqed_sat_counter #(
  parameter int unsigned    W   = 8,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign sat = (cnt_q == MAX);

endmodule

// File: rtl/aqed_fifo_fc_checker.sv
// A-QED functional-consistency / response-bound monitor for a FIFO-mode core.
// Snoops push (in_valid & ~full) and pop (out_valid & out_ready) handshakes.
// exec_dup picks an "original" push; a later exec_dup push with equal data is
// the "duplicate". When both pops are captured, qed_done rises and qed_check
// reports whether they returned equal data. rb_fail flags a duplicate that is
// not popped within RB_BOUND cycles of its push.
//   clk, reset          : clock, asynchronous active-low reset
//   in_valid/in_data    : push side, full : core full
//   out_valid/out_ready : pop handshake, out_data : popped data
//   exec_dup            : free selection marker
//   qed_done, qed_check, rb_fail, busy : results
module aqed_fifo_fc_checker
  import aqed_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned IDX_W    = 8,
  parameter int unsigned RB_BOUND = 32,
  parameter int unsigned RB_EN    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              full,
  input  logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] out_data,
  input  logic              exec_dup,
  output logic              qed_done,
  output logic              qed_check,
  output logic              rb_fail,
  output logic              busy
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(sat_max(IDX_W));

  logic             push, pop, pop_ok;
  logic [IDX_W-1:0] push_cnt, pop_cnt;
  logic             push_sat, pop_sat;

  aqed_state_t       state_q, state_d;
  logic [DATA_W-1:0] orig_data_q, orig_data_d;
  logic [IDX_W-1:0]  orig_idx_q, orig_idx_d;
  logic [IDX_W-1:0]  dup_idx_q, dup_idx_d;
  aqed_cap_t         orig_cap_q, orig_cap_d;
  aqed_cap_t         dup_cap_q, dup_cap_d;
  logic              qed_check_q, qed_check_d;
  logic              orig_sel, dup_sel, both_seen;

  assign push = in_valid & ~full;
  assign pop  = out_valid & out_ready;

  aqed_sat_counter #(.W(IDX_W), .MAX(IDX_MAX)) u_push_cnt (
    .clk(clk), .rst_n(reset), .clr(1'b0), .inc(push), .cnt(push_cnt), .sat(push_sat)
  );

  aqed_sat_counter #(.W(IDX_W), .MAX(IDX_MAX)) u_pop_cnt (
    .clk(clk), .rst_n(reset), .clr(1'b0), .inc(pop), .cnt(pop_cnt), .sat(pop_sat)
  );

  // Selected indices are never IDX_MAX, so a pop at a saturated pop_cnt can
  // never belong to a tracked transaction.
  assign pop_ok = pop & ~pop_sat;

  always_comb begin
    orig_sel = (state_q == IDLE) && push && exec_dup && !push_sat;
    dup_sel  = (state_q == ORIG) && push && exec_dup && !push_sat &&
               (in_data == orig_data_q);

    orig_data_d = orig_sel ? in_data  : orig_data_q;
    orig_idx_d  = orig_sel ? push_cnt : orig_idx_q;
    dup_idx_d   = dup_sel  ? push_cnt : dup_idx_q;

    // Captures compare the pre-increment pop_cnt against the index selected
    // this cycle (if any), so a same-cycle select and pop can still match.
    orig_cap_d = orig_cap_q;
    dup_cap_d  = dup_cap_q;
    if (pop_ok && (orig_sel || state_q == ORIG || state_q == DUP) &&
        (pop_cnt == orig_idx_d)) begin
      orig_cap_d = '{data: CAP_W'(out_data), seen: 1'b1};
    end
    if (pop_ok && (dup_sel || state_q == DUP) && (pop_cnt == dup_idx_d)) begin
      dup_cap_d = '{data: CAP_W'(out_data), seen: 1'b1};
    end
    both_seen = orig_cap_d.seen && dup_cap_d.seen;

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (orig_sel) state_d = ORIG;
      ORIG:    if (dup_sel)  state_d = both_seen ? DONE : DUP;
      DUP:     if (both_seen) state_d = DONE;
      default: state_d = DONE;
    endcase

    qed_check_d = qed_check_q;
    if ((state_q != DONE) && (state_d == DONE)) begin
      qed_check_d = (orig_cap_d.data == dup_cap_d.data);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      orig_data_q <= '0;
      orig_idx_q  <= '0;
      dup_idx_q   <= '0;
      orig_cap_q  <= '0;
      dup_cap_q   <= '0;
      qed_check_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      orig_data_q <= orig_data_d;
      orig_idx_q  <= orig_idx_d;
      dup_idx_q   <= dup_idx_d;
      orig_cap_q  <= orig_cap_d;
      dup_cap_q   <= dup_cap_d;
      qed_check_q <= qed_check_d;
    end
  end

  assign qed_done  = (state_q == DONE);
  assign qed_check = qed_check_q;
  assign busy      = (state_q != IDLE);

  if (RB_EN != 0) begin : g_rb
    localparam int unsigned LAT_W = $clog2(RB_BOUND + 1);

    logic [LAT_W-1:0] lat_cnt;
    logic             lat_sat, lat_inc, rb_now, rb_fail_q;

    assign lat_inc = (state_q == DUP) && !dup_cap_q.seen && !lat_sat;

    aqed_sat_counter #(.W(LAT_W), .MAX(LAT_W'(RB_BOUND))) u_lat_cnt (
      .clk(clk), .rst_n(reset), .clr(dup_sel), .inc(lat_inc), .cnt(lat_cnt), .sat(lat_sat)
    );

    // lat_cnt and dup_seen update on the same edge, so a duplicate popped in
    // the last permitted cycle clears the condition as lat_cnt hits the bound.
    assign rb_now = (state_q == DUP) && !dup_cap_q.seen &&
                    (lat_cnt == LAT_W'(RB_BOUND));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) rb_fail_q <= 1'b0;
      else        rb_fail_q <= rb_fail_q | rb_now;
    end

    assign rb_fail = rb_fail_q | rb_now;
  end else begin : g_no_rb
    assign rb_fail = 1'b0;
  end

endmodule

// File: tb/tb_aqed_fifo_fc_checker.sv
module tb_aqed_fifo_fc_checker;

  localparam int unsigned RB_B    = 4;
  localparam int          IDX_MAX = 255;
  localparam int          DEPTH   = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, full = 1'b0, out_valid = 1'b0, out_ready = 1'b0, exec_dup = 1'b0;
  logic [15:0] in_data = '0, out_data = '0;
  logic        qed_done, qed_check, rb_fail, busy;
  logic        qed_done_n, qed_check_n, rb_fail_n, busy_n;

  int edge_cnt = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  aqed_fifo_fc_checker #(.DATA_W(16), .IDX_W(8), .RB_BOUND(RB_B), .RB_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .full(full),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .exec_dup(exec_dup),
    .qed_done(qed_done), .qed_check(qed_check), .rb_fail(rb_fail), .busy(busy)
  );

  aqed_fifo_fc_checker #(.DATA_W(16), .IDX_W(8), .RB_BOUND(RB_B), .RB_EN(0)) dut_norb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .full(full),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .exec_dup(exec_dup),
    .qed_done(qed_done_n), .qed_check(qed_check_n), .rb_fail(rb_fail_n), .busy(busy_n)
  );

  // Scoreboard entry: kind 0 = qed_done rises, kind 1 = rb_fail rises.
  typedef struct {
    int kind;
    int cyc;
    bit chk;
  } exp_t;
  exp_t sb[$];

  logic [15:0] fifo[$];

  // Transaction-level reference state.
  int          m_push_n, m_pop_n, m_orig_idx, m_dup_idx, m_dup_edge;
  bit          m_have_orig, m_have_dup, m_got_o, m_got_d, m_finished, m_chk, m_rb;
  logic [15:0] m_orig_val, m_o_val, m_d_val;

  logic [15:0] alpha [4] = '{16'h00AA, 16'h0011, 16'h0005, 16'h0006};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic model_clear();
    m_push_n = 0; m_pop_n = 0; m_orig_idx = 0; m_dup_idx = 0; m_dup_edge = 0;
    m_have_orig = 0; m_have_dup = 0; m_got_o = 0; m_got_d = 0;
    m_finished = 0; m_chk = 1; m_rb = 0;
    m_orig_val = '0; m_o_val = '0; m_d_val = '0;
  endtask

  // Applies the transactions of the coming clock edge to the reference model.
  task automatic model_edge(input bit psh, input logic [15:0] d, input bit ed,
                            input bit pp, input logic [15:0] od);
    int e;
    e = edge_cnt + 1;
    if (psh && ed && m_push_n < IDX_MAX) begin
      if (!m_have_orig) begin
        m_have_orig = 1; m_orig_idx = m_push_n; m_orig_val = d;
      end else if (!m_have_dup && d == m_orig_val) begin
        m_have_dup = 1; m_dup_idx = m_push_n; m_dup_edge = e;
      end
    end
    if (pp && !m_finished) begin
      if (m_have_orig && !m_got_o && m_pop_n == m_orig_idx) begin m_got_o = 1; m_o_val = od; end
      if (m_have_dup  && !m_got_d && m_pop_n == m_dup_idx)  begin m_got_d = 1; m_d_val = od; end
    end
    if (m_got_o && m_got_d && !m_finished) begin
      m_finished = 1;
      m_chk = (m_o_val == m_d_val);
      sb.push_back('{0, e, m_chk});
    end
    if (m_have_dup && !m_got_d && !m_rb && e == m_dup_edge + int'(RB_B)) begin
      m_rb = 1;
      sb.push_back('{1, e, 1'b1});
    end
    if (psh && m_push_n < IDX_MAX) m_push_n++;
    if (pp && m_pop_n < IDX_MAX)   m_pop_n++;
  endtask

  // One cycle of the emulated FIFO core: drive, predict, update storage.
  task automatic step(input bit iv, input logic [15:0] d, input bit ed,
                      input bit rdy, input bit ff, input bit corrupt);
    logic [15:0] od;
    bit          do_push, do_pop;
    @(posedge clk);
    #2;
    full      = ff || (fifo.size() >= DEPTH);
    in_valid  = iv;
    in_data   = d;
    exec_dup  = ed;
    out_valid = (fifo.size() != 0);
    od        = out_valid ? fifo[0] : 16'h0000;
    if (corrupt && out_valid) od = od ^ 16'h0001;
    out_data  = od;
    out_ready = rdy;
    do_push   = iv && !full;
    do_pop    = out_valid && rdy;
    model_edge(do_push, d, ed, do_pop, od);
    if (do_pop)  void'(fifo.pop_front());
    if (do_push) fifo.push_back(d);
  endtask

  task automatic monitor();
    bit pd, pr;
    pd = 0; pr = 0;
    forever begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc < edge_cnt) begin
        checks++; errors++;
        $display("FAIL sb_missing: event kind %0d required at edge %0d, actual none by edge %0d",
                 sb[0].kind, sb[0].cyc, edge_cnt);
        void'(sb.pop_front());
      end
      if (qed_done && !pd) begin
        if (sb.size() != 0 && sb[0].kind == 0 && sb[0].cyc == edge_cnt) begin
          chk("qed_check_at_done", qed_check, sb[0].chk);
          void'(sb.pop_front());
        end else begin
          checks++; errors++;
          $display("FAIL done_unexpected: actual qed_done rise at edge %0d, required none", edge_cnt);
        end
      end
      if (rb_fail && !pr) begin
        if (sb.size() != 0 && sb[0].kind == 1 && sb[0].cyc == edge_cnt) begin
          chk("rb_fail_rise", rb_fail, 1'b1);
          void'(sb.pop_front());
        end else begin
          checks++; errors++;
          $display("FAIL rb_unexpected: actual rb_fail rise at edge %0d, required none", edge_cnt);
        end
      end
      pd = qed_done;
      pr = rb_fail;
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_qed_done", qed_done, 1'b0);
    chk("rst_qed_check", qed_check, 1'b1);
    chk("rst_rb_fail", rb_fail, 1'b0);
    chk("rst_busy", busy, 1'b0);
    model_clear();
    sb.delete();
    fifo.delete();
    in_valid = 0; full = 0; out_valid = 0; out_ready = 0; exec_dup = 0;
    in_data = '0; out_data = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic end_checks();
    step(0, 16'h0, 0, 0, 0, 0);
    step(0, 16'h0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    chk("end_busy", busy, m_have_orig);
    chk("end_qed_done", qed_done, m_finished);
    chk("end_qed_check", qed_check, m_chk);
    chk("end_rb_fail", rb_fail, m_rb);
    chk("norb_rb_fail", rb_fail_n, 1'b0);
    chk("norb_qed_done", qed_done_n, m_finished);
    chk("norb_qed_check", qed_check_n, m_chk);
    chk("norb_busy", busy_n, m_have_orig);
  endtask

  task automatic rand_episode(input int ncyc, input int rdy_pct, input bit cor_en, input bit late_sel);
    bit          iv, ed, rdy, ff, cor;
    logic [15:0] d;
    for (int c = 0; c < ncyc; c++) begin
      iv  = ($urandom_range(99) < 70);
      d   = alpha[$urandom_range(3)];
      if (late_sel) ed = (m_push_n >= 250) && ($urandom_range(1) == 1);
      else          ed = ($urandom_range(3) == 0);
      rdy = ($urandom_range(99) < rdy_pct);
      ff  = ($urandom_range(15) == 0);
      cor = cor_en && ($urandom_range(2) == 0);
      step(iv, d, ed, rdy, ff, cor);
    end
  endtask

  initial begin
    int n, rp;
    model_clear();
    fork
      monitor();
    join_none

    // A, B, A with consistent pops.
    do_reset();
    step(1, 16'h00AA, 1, 0, 0, 0);
    step(1, 16'h0011, 0, 0, 0, 0);
    step(1, 16'h00AA, 1, 0, 0, 0);
    repeat (3) step(0, 16'h0, 0, 1, 0, 0);
    end_checks();

    // Same, third pop corrupted to 16'h00AB.
    do_reset();
    step(1, 16'h00AA, 1, 0, 0, 0);
    step(1, 16'h0011, 0, 0, 0, 0);
    step(1, 16'h00AA, 1, 0, 0, 0);
    step(0, 16'h0, 0, 1, 0, 0);
    step(0, 16'h0, 0, 1, 0, 0);
    step(0, 16'h0, 0, 1, 0, 1);
    end_checks();

    // Mismatching exec_dup push is ignored; duplicate lands on index 2.
    do_reset();
    step(1, 16'h0005, 1, 0, 0, 0);
    step(1, 16'h0006, 1, 0, 0, 0);
    step(1, 16'h0005, 1, 0, 0, 0);
    repeat (3) step(0, 16'h0, 0, 1, 0, 0);
    end_checks();

    // Duplicate held in the FIFO past the response bound.
    do_reset();
    step(1, 16'h00AA, 1, 0, 0, 0);
    step(1, 16'h00AA, 1, 0, 0, 0);
    repeat (10) step(0, 16'h0, 0, 0, 0, 0);
    repeat (3) step(0, 16'h0, 0, 1, 0, 0);
    end_checks();

    // exec_dup push refused by full: no selection, index not consumed.
    do_reset();
    step(1, 16'h00AA, 1, 0, 1, 0);
    step(1, 16'h0011, 1, 0, 0, 0);
    step(1, 16'h0006, 0, 0, 0, 0);
    step(1, 16'h0011, 1, 0, 0, 0);
    repeat (4) step(0, 16'h0, 0, 1, 0, 0);
    end_checks();

    // Reset while in DUP, then a fresh pair from index 0.
    do_reset();
    step(1, 16'h00AA, 1, 0, 0, 0);
    step(1, 16'h00AA, 1, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("pre_reset_busy", busy, m_have_orig);
    do_reset();
    step(1, 16'h0011, 1, 0, 0, 0);
    step(1, 16'h0011, 1, 0, 0, 0);
    repeat (3) step(0, 16'h0, 0, 1, 0, 0);
    end_checks();

    for (int ep = 0; ep < 14; ep++) begin
      n  = $urandom_range(400, 80);
      rp = $urandom_range(90, 15);
      do_reset();
      rand_episode(n, rp, (ep % 3) == 1, 1'b0);
      end_checks();
    end

    // Long stream so selection happens near or at push-counter saturation.
    do_reset();
    rand_episode(700, 85, 1'b0, 1'b1);
    end_checks();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
